// File: rtl/serv_rvfi_monitor.sv
// serv_rvfi_monitor: RVFI retirement monitor for the bit-serial core, W bits per cycle.
// Latency: a record is pushed at the edge that ends the retire cycle and is visible as head one cycle later.
// Backpressure: valid/ready on the head record; a retire into a full FIFO without a same-cycle pop is dropped
//   and sets the sticky o_overflow flag (the order counter still advances, so the gap is visible).
//
// Ports: clk / i_rst_n (async, active-low); serial regfile streams i_rs_en/i_rs1/i_rs2 and i_rd_en/i_rd
//   (LSB-first); i_pc_en plus ibus address/data, decoded register addresses and i_trap describe the retiring
//   instruction; o_rvfi_* present the head record (all zero when empty); o_overflow, o_level report FIFO state.
// Optional macro SERV_RVFI_MEM_EN adds the dbus capture ports and the o_rvfi_mem_* record fields.

// Generic FWFT FIFO used for the record queue.
// Latency: push visible at the head one cycle later; pop on the edge with pop=1.
// Backpressure: caller must not push when full unless popping in the same cycle.
module serv_rvfi_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  assign dout  = mem[rd_ptr];
  assign valid = (count != '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign level = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module serv_rvfi_monitor #(
  parameter int          W        = 1,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd8
) (
  input  logic                      clk,
  input  logic                      i_rst_n,
  input  logic                      i_rs_en,
  input  logic [W-1:0]              i_rs1,
  input  logic [W-1:0]              i_rs2,
  input  logic                      i_rd_en,
  input  logic [W-1:0]              i_rd,
  input  logic                      i_pc_en,
  input  logic [31:0]               i_ibus_adr,
  input  logic [31:0]               i_ibus_rdt,
  input  logic [4:0]                i_rs1_addr,
  input  logic [4:0]                i_rs2_addr,
  input  logic [4:0]                i_rd_addr,
  input  logic                      i_trap,
  input  logic                      i_rvfi_ready,
`ifdef SERV_RVFI_MEM_EN
  input  logic [31:0]               i_dbus_adr,
  input  logic [31:0]               i_dbus_dat,
  input  logic [3:0]                i_dbus_sel,
  input  logic                      i_dbus_we,
  input  logic [31:0]               i_dbus_rdt,
  input  logic                      i_dbus_ack,
  output logic [31:0]               o_rvfi_mem_addr,
  output logic [31:0]               o_rvfi_mem_rdata,
  output logic [31:0]               o_rvfi_mem_wdata,
  output logic [3:0]                o_rvfi_mem_rmask,
  output logic [3:0]                o_rvfi_mem_wmask,
`endif
  output logic                      o_rvfi_valid,
  output logic [63:0]               o_rvfi_order,
  output logic [31:0]               o_rvfi_insn,
  output logic [31:0]               o_rvfi_pc_rdata,
  output logic [31:0]               o_rvfi_pc_wdata,
  output logic [4:0]                o_rvfi_rs1_addr,
  output logic [4:0]                o_rvfi_rs2_addr,
  output logic [4:0]                o_rvfi_rd_addr,
  output logic [31:0]               o_rvfi_rs1_rdata,
  output logic [31:0]               o_rvfi_rs2_rdata,
  output logic [31:0]               o_rvfi_rd_wdata,
  output logic                      o_rvfi_trap,
  output logic                      o_overflow,
  output logic [$clog2(DEPTH):0]    o_level
);
  if (!(W == 1 || W == 2 || W == 4 || W == 8 || W == 16 || W == 32)) begin : g_bad_w
    $error("serv_rvfi_monitor: W must be 1, 2, 4, 8, 16 or 32");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("serv_rvfi_monitor: DEPTH must be a power of two >= 2");
  end

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] insn;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [31:0] rd_wdata;
    logic        trap;
`ifdef SERV_RVFI_MEM_EN
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
`endif
  } rec_t;

  // New beat enters at the top so that after 32/W beats the first beat sits in the LSBs.
  function automatic logic [31:0] shift_in(input logic [31:0] sh, input logic [W-1:0] d);
    shift_in = (sh >> W) | (32'(d) << (32 - W));
  endfunction

  logic [31:0] rs1_sh, rs2_sh, rd_sh, shadow_pc;
  logic [63:0] order;
  logic        pc_en_r, retire, pop, push, full, head_vld, overflow;
  rec_t        rec, head_raw, head;

  // Retirement is the falling edge of the core's PC-update enable.
  assign retire = pc_en_r & ~i_pc_en;
  assign pop    = head_vld & i_rvfi_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push   = retire & (~full | pop);

`ifdef SERV_RVFI_MEM_EN
  logic [31:0] cap_addr, cap_rdata, cap_wdata;
  logic [3:0]  cap_rmask, cap_wmask;
`endif

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rs1_sh    <= '0;
      rs2_sh    <= '0;
      rd_sh     <= '0;
      pc_en_r   <= 1'b0;
      shadow_pc <= RESET_PC;
      order     <= '0;
      overflow  <= 1'b0;
`ifdef SERV_RVFI_MEM_EN
      cap_addr  <= '0;
      cap_rdata <= '0;
      cap_wdata <= '0;
      cap_rmask <= '0;
      cap_wmask <= '0;
`endif
    end else begin
      pc_en_r <= i_pc_en;
      if (i_rs_en) begin
        rs1_sh <= shift_in(rs1_sh, i_rs1);
        rs2_sh <= shift_in(rs2_sh, i_rs2);
      end
      if (retire)       rd_sh <= '0;
      else if (i_rd_en) rd_sh <= shift_in(rd_sh, i_rd);
      if (retire) begin
        shadow_pc <= i_ibus_adr;
        order     <= order + 64'd1;
        if (full && !pop) overflow <= 1'b1;
      end
`ifdef SERV_RVFI_MEM_EN
      if (retire) begin
        cap_addr  <= '0;
        cap_rdata <= '0;
        cap_wdata <= '0;
        cap_rmask <= '0;
        cap_wmask <= '0;
      end else if (i_dbus_ack) begin
        cap_addr  <= i_dbus_adr;
        cap_rdata <= i_dbus_rdt;
        cap_wdata <= i_dbus_dat;
        cap_rmask <= i_dbus_we ? 4'h0 : i_dbus_sel;
        cap_wmask <= i_dbus_we ? i_dbus_sel : 4'h0;
      end
`endif
    end
  end

  always_comb begin
    rec           = '0;
    rec.order     = order;
    rec.insn      = i_ibus_rdt;
    rec.pc_rdata  = shadow_pc;
    rec.pc_wdata  = i_ibus_adr;
    rec.rs1_addr  = i_rs1_addr;
    rec.rs2_addr  = i_rs2_addr;
    rec.rd_addr   = i_rd_addr;
    rec.rs1_rdata = rs1_sh;
    rec.rs2_rdata = rs2_sh;
    rec.rd_wdata  = (i_rd_addr == 5'd0) ? 32'd0 : rd_sh;
    rec.trap      = i_trap;
`ifdef SERV_RVFI_MEM_EN
    // An ack landing in the retire cycle itself still belongs to this instruction.
    rec.mem_addr  = i_dbus_ack ? i_dbus_adr : cap_addr;
    rec.mem_rdata = i_dbus_ack ? i_dbus_rdt : cap_rdata;
    rec.mem_wdata = i_dbus_ack ? i_dbus_dat : cap_wdata;
    rec.mem_rmask = i_dbus_ack ? (i_dbus_we ? 4'h0 : i_dbus_sel) : cap_rmask;
    rec.mem_wmask = i_dbus_ack ? (i_dbus_we ? i_dbus_sel : 4'h0) : cap_wmask;
`endif
  end

  serv_rvfi_fifo #(.WIDTH($bits(rec_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (i_rst_n),
    .push  (push),
    .din   (rec),
    .pop   (pop),
    .dout  (head_raw),
    .valid (head_vld),
    .full  (full),
    .level (o_level)
  );

  // Stale storage is hidden so an empty queue reads as all zeros.
  assign head = head_vld ? head_raw : '0;

  assign o_rvfi_valid     = head_vld;
  assign o_rvfi_order     = head.order;
  assign o_rvfi_insn      = head.insn;
  assign o_rvfi_pc_rdata  = head.pc_rdata;
  assign o_rvfi_pc_wdata  = head.pc_wdata;
  assign o_rvfi_rs1_addr  = head.rs1_addr;
  assign o_rvfi_rs2_addr  = head.rs2_addr;
  assign o_rvfi_rd_addr   = head.rd_addr;
  assign o_rvfi_rs1_rdata = head.rs1_rdata;
  assign o_rvfi_rs2_rdata = head.rs2_rdata;
  assign o_rvfi_rd_wdata  = head.rd_wdata;
  assign o_rvfi_trap      = head.trap;
  assign o_overflow       = overflow;
`ifdef SERV_RVFI_MEM_EN
  assign o_rvfi_mem_addr  = head.mem_addr;
  assign o_rvfi_mem_rdata = head.mem_rdata;
  assign o_rvfi_mem_wdata = head.mem_wdata;
  assign o_rvfi_mem_rmask = head.mem_rmask;
  assign o_rvfi_mem_wmask = head.mem_wmask;
`endif
endmodule

// File: tb/tb_serv_rvfi_monitor.sv
// tb_serv_rvfi_monitor: directed bench for serv_rvfi_monitor with W=4, DEPTH=4, RESET_PC=8.
// Latency: inputs change and outputs are sampled 1 time unit after each rising clock edge.
// Backpressure: i_rvfi_ready is driven explicitly per scenario to exercise full/drop/pop paths.
module tb_serv_rvfi_monitor;
  localparam int TW = 4;
  localparam int TD = 4;

  logic          clk = 1'b0;
  logic          i_rst_n;
  logic          i_rs_en, i_rd_en, i_pc_en, i_trap, i_rvfi_ready;
  logic [TW-1:0] i_rs1, i_rs2, i_rd;
  logic [31:0]   i_ibus_adr, i_ibus_rdt;
  logic [4:0]    i_rs1_addr, i_rs2_addr, i_rd_addr;
  logic          o_rvfi_valid, o_rvfi_trap, o_overflow;
  logic [63:0]   o_rvfi_order;
  logic [31:0]   o_rvfi_insn, o_rvfi_pc_rdata, o_rvfi_pc_wdata;
  logic [4:0]    o_rvfi_rs1_addr, o_rvfi_rs2_addr, o_rvfi_rd_addr;
  logic [31:0]   o_rvfi_rs1_rdata, o_rvfi_rs2_rdata, o_rvfi_rd_wdata;
  logic [$clog2(TD):0] o_level;
`ifdef SERV_RVFI_MEM_EN
  logic [31:0]   i_dbus_adr, i_dbus_dat, i_dbus_rdt;
  logic [3:0]    i_dbus_sel;
  logic          i_dbus_we, i_dbus_ack;
  logic [31:0]   o_rvfi_mem_addr, o_rvfi_mem_rdata, o_rvfi_mem_wdata;
  logic [3:0]    o_rvfi_mem_rmask, o_rvfi_mem_wmask;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serv_rvfi_monitor #(.W(TW), .DEPTH(TD), .RESET_PC(32'd8)) dut (
    .clk              (clk),
    .i_rst_n          (i_rst_n),
    .i_rs_en          (i_rs_en),
    .i_rs1            (i_rs1),
    .i_rs2            (i_rs2),
    .i_rd_en          (i_rd_en),
    .i_rd             (i_rd),
    .i_pc_en          (i_pc_en),
    .i_ibus_adr       (i_ibus_adr),
    .i_ibus_rdt       (i_ibus_rdt),
    .i_rs1_addr       (i_rs1_addr),
    .i_rs2_addr       (i_rs2_addr),
    .i_rd_addr        (i_rd_addr),
    .i_trap           (i_trap),
    .i_rvfi_ready     (i_rvfi_ready),
`ifdef SERV_RVFI_MEM_EN
    .i_dbus_adr       (i_dbus_adr),
    .i_dbus_dat       (i_dbus_dat),
    .i_dbus_sel       (i_dbus_sel),
    .i_dbus_we        (i_dbus_we),
    .i_dbus_rdt       (i_dbus_rdt),
    .i_dbus_ack       (i_dbus_ack),
    .o_rvfi_mem_addr  (o_rvfi_mem_addr),
    .o_rvfi_mem_rdata (o_rvfi_mem_rdata),
    .o_rvfi_mem_wdata (o_rvfi_mem_wdata),
    .o_rvfi_mem_rmask (o_rvfi_mem_rmask),
    .o_rvfi_mem_wmask (o_rvfi_mem_wmask),
`endif
    .o_rvfi_valid     (o_rvfi_valid),
    .o_rvfi_order     (o_rvfi_order),
    .o_rvfi_insn      (o_rvfi_insn),
    .o_rvfi_pc_rdata  (o_rvfi_pc_rdata),
    .o_rvfi_pc_wdata  (o_rvfi_pc_wdata),
    .o_rvfi_rs1_addr  (o_rvfi_rs1_addr),
    .o_rvfi_rs2_addr  (o_rvfi_rs2_addr),
    .o_rvfi_rd_addr   (o_rvfi_rd_addr),
    .o_rvfi_rs1_rdata (o_rvfi_rs1_rdata),
    .o_rvfi_rs2_rdata (o_rvfi_rs2_rdata),
    .o_rvfi_rd_wdata  (o_rvfi_rd_wdata),
    .o_rvfi_trap      (o_rvfi_trap),
    .o_overflow       (o_overflow),
    .o_level          (o_level)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shift(input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] vd,
                       input logic en_rs, input logic en_rd, input int beats);
    for (int b = 0; b < beats; b++) begin
      i_rs_en = en_rs;
      i_rd_en = en_rd;
      i_rs1   = v1[b*TW +: TW];
      i_rs2   = v2[b*TW +: TW];
      i_rd    = vd[b*TW +: TW];
      step();
    end
    i_rs_en = 1'b0;
    i_rd_en = 1'b0;
  endtask

  // One cycle of pc_en high, then the falling cycle is the retire cycle.
  task automatic retire(input logic [31:0] adr, input logic [31:0] insn, input logic [4:0] rd_a,
                        input logic trap, input logic rdy_on_r);
    i_pc_en = 1'b1;
    step();
    i_pc_en      = 1'b0;
    i_ibus_adr   = adr;
    i_ibus_rdt   = insn;
    i_rs1_addr   = 5'd1;
    i_rs2_addr   = 5'd2;
    i_rd_addr    = rd_a;
    i_trap       = trap;
    i_rvfi_ready = rdy_on_r;
    step();
    i_rvfi_ready = 1'b0;
    i_trap       = 1'b0;
  endtask

  task automatic pop_one();
    i_rvfi_ready = 1'b1;
    step();
    i_rvfi_ready = 1'b0;
  endtask

  initial begin
    i_rst_n = 1'b0; i_rs_en = 0; i_rd_en = 0; i_pc_en = 0; i_trap = 0; i_rvfi_ready = 0;
    i_rs1 = '0; i_rs2 = '0; i_rd = '0; i_ibus_adr = '0; i_ibus_rdt = '0;
    i_rs1_addr = '0; i_rs2_addr = '0; i_rd_addr = '0;
`ifdef SERV_RVFI_MEM_EN
    i_dbus_adr = '0; i_dbus_dat = '0; i_dbus_sel = '0; i_dbus_we = 0; i_dbus_rdt = '0; i_dbus_ack = 0;
`endif
    step(); step();
    check("rst_valid", 64'(o_rvfi_valid), 64'd0);
    check("rst_level", 64'(o_level), 64'd0);
    check("rst_overflow", 64'(o_overflow), 64'd0);
    check("rst_pc_rdata", 64'(o_rvfi_pc_rdata), 64'd0);
    i_rst_n = 1'b1;
    step();

    // rs1/rs2 reconstruction and PC tracking
    shift(32'hDEADBEEF, 32'h01234567, 32'h0, 1'b1, 1'b0, 8);
    retire(32'hC, 32'h00000013, 5'd0, 1'b0, 1'b0);
    check("t1_valid", 64'(o_rvfi_valid), 64'd1);
    check("t1_rs1", 64'(o_rvfi_rs1_rdata), 64'hDEADBEEF);
    check("t1_rs2", 64'(o_rvfi_rs2_rdata), 64'h01234567);
    check("t1_pc_rdata", 64'(o_rvfi_pc_rdata), 64'h8);
    check("t1_pc_wdata", 64'(o_rvfi_pc_wdata), 64'hC);
    check("t1_order", o_rvfi_order, 64'd0);
    check("t1_insn", 64'(o_rvfi_insn), 64'h13);
    check("t1_level", 64'(o_level), 64'd1);
    pop_one();
    check("t1_pop_valid", 64'(o_rvfi_valid), 64'd0);

    // rd reconstruction, x0 suppression, rd cleared at retire, trap flag
    shift(32'h0, 32'h0, 32'h12345678, 1'b0, 1'b1, 8);
    retire(32'h10, 32'h00500293, 5'd5, 1'b0, 1'b0);
    check("t2_rd_wdata", 64'(o_rvfi_rd_wdata), 64'h12345678);
    check("t2_rd_addr", 64'(o_rvfi_rd_addr), 64'd5);
    check("t2_order", o_rvfi_order, 64'd1);
    check("t2_pc_rdata", 64'(o_rvfi_pc_rdata), 64'hC);
    check("t2_rs1_kept", 64'(o_rvfi_rs1_rdata), 64'hDEADBEEF);
    pop_one();
    shift(32'h0, 32'h0, 32'h12345678, 1'b0, 1'b1, 8);
    retire(32'h14, 32'h00000013, 5'd0, 1'b0, 1'b0);
    check("t2_x0_wdata", 64'(o_rvfi_rd_wdata), 64'd0);
    check("t2_x0_order", o_rvfi_order, 64'd2);
    pop_one();
    retire(32'h18, 32'h00000073, 5'd5, 1'b1, 1'b0);
    check("t2_rd_cleared", 64'(o_rvfi_rd_wdata), 64'd0);
    check("t2_trap", 64'(o_rvfi_trap), 64'd1);
    pop_one();

    // fill, full with same-cycle pop, then drop on full
    retire(32'h20, 32'h1, 5'd0, 1'b0, 1'b0);
    retire(32'h24, 32'h2, 5'd0, 1'b0, 1'b0);
    retire(32'h28, 32'h3, 5'd0, 1'b0, 1'b0);
    retire(32'h2C, 32'h4, 5'd0, 1'b0, 1'b0);
    check("fill_level", 64'(o_level), 64'd4);
    check("fill_head_order", o_rvfi_order, 64'd4);
    retire(32'h30, 32'h5, 5'd0, 1'b0, 1'b1);
    check("fr_level", 64'(o_level), 64'd4);
    check("fr_overflow", 64'(o_overflow), 64'd0);
    check("fr_head_order", o_rvfi_order, 64'd5);
    check("fr_head_pc_rdata", 64'(o_rvfi_pc_rdata), 64'h20);
    retire(32'h34, 32'h6, 5'd0, 1'b0, 1'b0);
    check("ov_level", 64'(o_level), 64'd4);
    check("ov_flag", 64'(o_overflow), 64'd1);
    check("drain_o5", o_rvfi_order, 64'd5); pop_one();
    check("drain_o6", o_rvfi_order, 64'd6); pop_one();
    check("drain_o7", o_rvfi_order, 64'd7); pop_one();
    check("drain_o8", o_rvfi_order, 64'd8);
    check("drain_o8_pcw", 64'(o_rvfi_pc_wdata), 64'h30); pop_one();
    check("drain_empty", 64'(o_rvfi_valid), 64'd0);
    pop_one();
    check("empty_pop_level", 64'(o_level), 64'd0);
    retire(32'h38, 32'h7, 5'd0, 1'b0, 1'b0);
    check("gap_order", o_rvfi_order, 64'd10);
    check("gap_pc_rdata", 64'(o_rvfi_pc_rdata), 64'h34);
    check("ov_sticky", 64'(o_overflow), 64'd1);

    // asynchronous reset in the middle of an instruction
    shift(32'hAAAA5555, 32'h0, 32'h5555AAAA, 1'b1, 1'b1, 4);
    check("pre_rst_level", 64'(o_level), 64'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(o_rvfi_valid), 64'd0);
    check("arst_level", 64'(o_level), 64'd0);
    check("arst_overflow", 64'(o_overflow), 64'd0);
    check("arst_order", o_rvfi_order, 64'd0);
    #2;
    i_rst_n = 1'b1;
    step();
    shift(32'h0BADF00D, 32'h0, 32'h0, 1'b1, 1'b0, 8);
    retire(32'h40, 32'h00300193, 5'd3, 1'b0, 1'b0);
    check("post_rst_order", o_rvfi_order, 64'd0);
    check("post_rst_pc_rdata", 64'(o_rvfi_pc_rdata), 64'h8);
    check("post_rst_rs1", 64'(o_rvfi_rs1_rdata), 64'h0BADF00D);
    check("post_rst_rd_discard", 64'(o_rvfi_rd_wdata), 64'd0);
    pop_one();

`ifdef SERV_RVFI_MEM_EN
    i_dbus_adr = 32'h100; i_dbus_dat = 32'hCAFE; i_dbus_sel = 4'h3; i_dbus_we = 1'b1; i_dbus_ack = 1'b1;
    step();
    i_dbus_ack = 1'b0;
    retire(32'h44, 32'h00A11023, 5'd0, 1'b0, 1'b0);
    check("mem_wmask", 64'(o_rvfi_mem_wmask), 64'h3);
    check("mem_rmask", 64'(o_rvfi_mem_rmask), 64'h0);
    check("mem_addr", 64'(o_rvfi_mem_addr), 64'h100);
    pop_one();
    retire(32'h48, 32'h00000013, 5'd0, 1'b0, 1'b0);
    check("mem_next_addr", 64'(o_rvfi_mem_addr), 64'h0);
    check("mem_next_wmask", 64'(o_rvfi_mem_wmask), 64'h0);
    pop_one();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
